// File: rtl/vram_scheduler.sv
// Arbitrates a single-port pixel RAM between fixed display fetch slots and a host port,
// and unpacks 4-bit pixels from fetched words for the VGA pipeline.
module vram_scheduler #(
  parameter int H_START  = 144,
  parameter int H_END    = 784,
  parameter int V_START  = 35,
  parameter int V_END    = 515,
  parameter int WORDS_PL = 160,
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              vga_active,
  input  logic              disp_en,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        pix_out,
  output logic              pix_valid,
  output logic              sof
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  // Fetch runs four clocks ahead of the pixels it feeds.
  localparam logic [9:0] SLOT_FIRST = 10'(H_START - 4);
  localparam logic [9:0] SLOT_END   = 10'(H_START - 4 + 4 * WORDS_PL);
  localparam logic [9:0] PIX_FIRST  = 10'(H_START);
  localparam logic [9:0] PIX_END    = 10'(H_END);
  localparam logic [9:0] LINE_FIRST = 10'(V_START);
  localparam logic [9:0] LINE_END   = 10'(V_END);
  localparam logic [9:0] H_LAST     = 10'd799;
  localparam logic [9:0] V_LAST     = 10'd524;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] disp_addr;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] fetch_buf;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_next;
  logic              dslot_q;
  logic              eof;
  logic              run;
  logic              dslot;
  logic              load;
  logic              grant;
  logic [1:0]        slot_phase;
  logic [1:0]        pix_phase;

  assign eof        = (hcount == H_LAST) && (vcount == V_LAST);
  assign run        = (state == S_RUN);
  assign slot_phase = hcount[1:0] - SLOT_FIRST[1:0];
  assign pix_phase  = hcount[1:0] - PIX_FIRST[1:0];

  assign dslot = run
              && (vcount >= LINE_FIRST) && (vcount < LINE_END)
              && (hcount >= SLOT_FIRST) && (hcount < SLOT_END)
              && (slot_phase == 2'b00);

  assign load = run && (hcount >= PIX_FIRST) && (hcount < PIX_END) && (pix_phase == 2'b00);

  // Held low during reset so no host access can start while the scheduler is cleared.
  assign host_ready = rst && !dslot;
  assign grant      = host_valid && host_ready;
  assign host_rdata = rst ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (eof) begin
      state_next = disp_en ? S_RUN : S_IDLE;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dslot) begin
      mem_en   = 1'b1;
      mem_addr = base_q + disp_addr;
    end else if (grant) begin
      mem_en   = 1'b1;
      mem_we   = host_we;
      mem_addr = host_addr;
      if (host_we) begin
        mem_wdata = host_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q    <= '0;
      disp_addr <= '0;
    end else if (eof) begin
      base_q    <= base_addr;
      disp_addr <= '0;
    end else if (dslot) begin
      disp_addr <= disp_addr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dslot_q   <= 1'b0;
      fetch_buf <= '0;
    end else begin
      dslot_q <= dslot;
      if (dslot_q) begin
        fetch_buf <= mem_rdata;
      end
    end
  end

  always_comb begin
    shreg_next = shreg;
    if (load) begin
      shreg_next = fetch_buf;
    end else if (vga_active) begin
      shreg_next = shreg >> 4;
    end
  end

  // pix_out takes the nibble of the word/shift being applied on this same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg       <= '0;
      pix_out     <= 4'd0;
      pix_valid   <= 1'b0;
      sof         <= 1'b0;
      host_rvalid <= 1'b0;
    end else begin
      shreg       <= shreg_next;
      pix_out     <= (vga_active && run) ? shreg_next[3:0] : 4'd0;
      pix_valid   <= vga_active;
      sof         <= eof;
      host_rvalid <= grant && !host_we;
    end
  end

endmodule
